scale_cfg_sequencer: RTL and testbench
======================================

// Module: scale_cfg_sequencer
// PURPOSE
//  Sequencer in front of the scale timing engine (timer + scalestate pair).
//  - Holds a DSP-written table of {loadchoice, datain} words.
//  - Replays the table into the engine's load port, then pulses scalstart.
//  - Waits for the engine's state-over strobe and repeats for N runs.
//  - Frees the DSP from hand-driving scaleload/scalechoice/scaledatain per run.
// PARAMETERS
//  DEPTH       16        table entries (power of two)
//  AW          4         log2(DEPTH)
//  TMO_W       24        width of the WAIT watchdog counter (timeout build only)
//  TMO_CYCLES  24'hFFFFF clk_sys cycles allowed in WAIT before timeout
// PORTS
//  clk_sys      in   1      system clock, all logic rising-edge
//  rst_n        in   1      asynchronous active-low reset
//  wr_en        in   1      table write strobe, accepted in IDLE only
//  wr_choice    in   5      loadchoice field of the written entry
//  wr_data      in   16     datain field of the written entry
//  tbl_clr      in   1      empty the table (IDLE only)
//  go           in   1      start a sequence (1-cycle strobe)
//  abort        in   1      abandon the sequence, any state
//  repeat_n     in   16     run count, latched at go; 0 is treated as 1
//  stateinter   in   1      engine state-over, active low
//  scaleload    out  1      1-cycle load strobe to the engine
//  scalechoice  out  5      loadchoice to the engine
//  scaledatain  out  16     datain to the engine
//  scalstart    out  1      1-cycle start strobe to the engine
//  busy         out  1      high in every state except IDLE
//  done         out  1      1-cycle pulse when all runs complete
//  tbl_full     out  1      entry count == DEPTH
//  tbl_cnt      out  AW+1   entries held
//  run_cnt      out  16     completed runs in the current sequence
//  err_timeout  out  1      sticky watchdog flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; table count 0; stateinter edge register 1.
//  Table writes
//   - Entry lands at wr_ptr = tbl_cnt, then tbl_cnt increments.
//   - Ignored when tbl_full, when busy, or when tbl_clr is high the same cycle.
//   - tbl_clr takes priority over wr_en. Both are ignored while busy.
//   - Table contents are never consumed; every run replays entries 0..tbl_cnt-1.
//  FSM: IDLE, LOAD, GAP, START, WAIT, NEXT.
//   IDLE
//    - go with tbl_cnt > 0: latch repeat_n (0 -> 1), clear run_cnt and err_timeout,
//      set rd_ptr = 0, go to LOAD.
//    - go with tbl_cnt == 0: ignored, no done pulse.
//   LOAD
//    - scalechoice/scaledatain = entry[rd_ptr], registered.
//    - scaleload = 1 for exactly this cycle, then go to GAP.
//   GAP
//    - scaleload = 0; data outputs hold their value.
//    - rd_ptr == tbl_cnt-1: go to START. Otherwise rd_ptr++ and go to LOAD.
//    - Net cost: 2 cycles per entry.
//   START: scalstart = 1 for one cycle, then go to WAIT.
//   WAIT
//    - Exit on a falling edge of stateinter: previous sample 1, current 0.
//    - A level-low stateinter with no edge never completes a run.
//    - An edge that arrives in LOAD, GAP or START is discarded.
//   NEXT
//    - run_cnt++.
//    - If run_cnt+1 == latched repeat: done = 1 for this cycle, go to IDLE.
//    - Otherwise rd_ptr = 0, go to LOAD.
//  go while busy: ignored.
//  abort
//   - In any state: IDLE on the next edge, with scaleload/scalstart forced 0.
//   - No done pulse. Table and run_cnt are kept.
//   - abort and go in the same cycle: abort wins.
//  Reset mid-sequence: the table is lost; all outputs return to reset values immediately.
//  Arithmetic: run_cnt saturates at 16'hFFFF. Pointers do not wrap, because tbl_cnt <= DEPTH.
// CONFIGURATION
//  SCALE_SEQ_TIMEOUT_EN defined
//   - A TMO_W counter clears on entry to WAIT and increments each WAIT cycle.
//   - When it reaches TMO_CYCLES: err_timeout = 1 (sticky), go to IDLE, no done.
//   - err_timeout is cleared only by an accepted go.
//  SCALE_SEQ_TIMEOUT_EN undefined
//   - err_timeout is tied 0, no counter is built, WAIT waits forever (abort exits).
// TESTING
//  T1
//   - Stimulus: write 3 entries {1,16'h0010},{2,16'h0020},{3,16'h0030}; go, repeat_n = 1.
//   - Response: scaleload pulses on cycles 1, 3, 5 with matching data; scalstart on cycle 7.
//   - Then drive stateinter 1->0: done the cycle after NEXT, run_cnt = 1.
//  T2
//   - Stimulus: same table, repeat_n = 0.
//   - Response: runs exactly once; repeat_n = 3 gives 9 scaleload pulses, 3 scalstart pulses, run_cnt = 3.
//  T3
//   - Stimulus: write 17 entries.
//   - Response: tbl_full after 16, 17th dropped, tbl_cnt = 16; go with an empty table: busy stays 0.
//  T4
//   - Stimulus: stateinter held low before go.
//   - Response: no completion until it rises and falls again in WAIT.
//   - An edge during GAP is ignored.
//  T5
//   - Stimulus: abort in WAIT on run 2 of 3.
//   - Response: IDLE the next cycle, no done, run_cnt = 1, table intact; wr_en while busy has no effect.
//  T6
//   - Build: SCALE_SEQ_TIMEOUT_EN with TMO_CYCLES = 100; no stateinter edge.
//   - Response: err_timeout = 1 at WAIT cycle 100, busy 0, done 0; the next go clears err_timeout.

Source files
------------

// File: rtl/scale_cfg_sequencer.sv
// Table-driven sequencer that replays {loadchoice, datain} words into the scale engine.
// Optional WAIT watchdog is built when SCALE_SEQ_TIMEOUT_EN is defined.
module scale_cfg_sequencer #(
  parameter int unsigned      DEPTH      = 16,
  parameter int unsigned      AW         = 4,
  parameter int unsigned      TMO_W      = 24,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 24'hFFFFF
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [4:0]    wr_choice,
  input  logic [15:0]   wr_data,
  input  logic          tbl_clr,
  input  logic          go,
  input  logic          abort,
  input  logic [15:0]   repeat_n,
  input  logic          stateinter,
  output logic          scaleload,
  output logic [4:0]    scalechoice,
  output logic [15:0]   scaledatain,
  output logic          scalstart,
  output logic          busy,
  output logic          done,
  output logic          tbl_full,
  output logic [AW:0]   tbl_cnt,
  output logic [15:0]   run_cnt,
  output logic          err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;

  if (AW != $clog2(DEPTH) || TMO_CYCLES == '0) begin : g_cfg_check
    $error("scale_cfg_sequencer: AW must equal log2(DEPTH) and TMO_CYCLES must be nonzero");
  end

  logic [2:0]    r_state;
  logic [2:0]    w_state_d;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_rd_ptr_d;
  logic [AW:0]   r_tbl_cnt;
  logic [20:0]   r_tbl [DEPTH];
  logic [15:0]   r_repeat;
  logic [15:0]   r_run_cnt;
  logic          r_si;
  logic          r_scaleload;
  logic          r_scalstart;
  logic [4:0]    r_choice;
  logic [15:0]   r_datain;
  logic          r_done;

  logic          w_idle;
  logic          w_full;
  logic          w_fall;
  logic          w_go_acc;
  logic          w_done_d;
  logic          w_run_inc_en;
  logic          w_last;
  logic          w_tbl_ok;
  logic          w_wr_acc;
  logic [15:0]   w_run_inc;

  assign w_idle    = (r_state == S_IDLE);
  assign w_full    = (r_tbl_cnt == (AW+1)'(DEPTH));
  assign w_fall    = r_si & ~stateinter;
  assign w_run_inc = (r_run_cnt == 16'hFFFF) ? r_run_cnt : r_run_cnt + 16'd1;
  assign w_last    = (({1'b0, r_run_cnt} + 17'd1) == {1'b0, r_repeat});

  // Table edits in the cycle a go is accepted are dropped so the replayed table is fixed.
  assign w_tbl_ok  = w_idle & ~w_go_acc;
  assign w_wr_acc  = w_tbl_ok & wr_en & ~tbl_clr & ~w_full;

`ifdef SCALE_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
  logic             w_err_set;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_rd_ptr_d   = r_rd_ptr;
    w_go_acc     = 1'b0;
    w_done_d     = 1'b0;
    w_run_inc_en = 1'b0;
`ifdef SCALE_SEQ_TIMEOUT_EN
    w_err_set    = 1'b0;
`endif
    if (abort) begin
      w_state_d = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go && (r_tbl_cnt != '0)) begin
            w_go_acc   = 1'b1;
            w_rd_ptr_d = '0;
            w_state_d  = S_LOAD;
          end
        end
        S_LOAD:  w_state_d = S_GAP;
        S_GAP: begin
          if ({1'b0, r_rd_ptr} == (r_tbl_cnt - 1'b1)) begin
            w_state_d = S_START;
          end else begin
            w_rd_ptr_d = r_rd_ptr + 1'b1;
            w_state_d  = S_LOAD;
          end
        end
        S_START: w_state_d = S_WAIT;
        S_WAIT: begin
          if (w_fall) begin
            w_state_d = S_NEXT;
          end
`ifdef SCALE_SEQ_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TMO_CYCLES - 1'b1)) begin
            w_state_d = S_IDLE;
            w_err_set = 1'b1;
          end
`endif
        end
        S_NEXT: begin
          w_run_inc_en = 1'b1;
          if (w_last) begin
            w_done_d  = 1'b1;
            w_state_d = S_IDLE;
          end else begin
            w_rd_ptr_d = '0;
            w_state_d  = S_LOAD;
          end
        end
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_tbl_cnt   <= '0;
      r_repeat    <= 16'd1;
      r_run_cnt   <= '0;
      r_si        <= 1'b1;
      r_scaleload <= 1'b0;
      r_scalstart <= 1'b0;
      r_choice    <= '0;
      r_datain    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_si        <= stateinter;
      r_done      <= w_done_d;
      // Strobes are registered against the next state so they line up with LOAD/START.
      r_scaleload <= (w_state_d == S_LOAD);
      r_scalstart <= (w_state_d == S_START);
      if (w_state_d == S_LOAD) begin
        r_choice <= r_tbl[w_rd_ptr_d][20:16];
        r_datain <= r_tbl[w_rd_ptr_d][15:0];
      end
      if (w_tbl_ok && tbl_clr) begin
        r_tbl_cnt <= '0;
      end else if (w_wr_acc) begin
        r_tbl_cnt <= r_tbl_cnt + 1'b1;
      end
      if (w_go_acc) begin
        r_repeat  <= (repeat_n == 16'd0) ? 16'd1 : repeat_n;
        r_run_cnt <= '0;
      end else if (w_run_inc_en) begin
        r_run_cnt <= w_run_inc;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_wr_acc) begin
      r_tbl[r_tbl_cnt[AW-1:0]] <= {wr_choice, wr_data};
    end
  end

`ifdef SCALE_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= (r_state == S_WAIT) ? r_tmo + 1'b1 : '0;
      if (w_go_acc) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_timeout = r_err;
`else
  assign err_timeout = 1'b0;
`endif

  assign scaleload   = r_scaleload;
  assign scalstart   = r_scalstart;
  assign scalechoice = r_choice;
  assign scaledatain = r_datain;
  assign busy        = ~w_idle;
  assign done        = r_done;
  assign tbl_full    = w_full;
  assign tbl_cnt     = r_tbl_cnt;
  assign run_cnt     = r_run_cnt;

endmodule

// File: tb/tb_scale_cfg_sequencer.sv
// Scoreboard bench for scale_cfg_sequencer; stimulus pushes expected strobes, a monitor pops them.
// Define SCALE_SEQ_TIMEOUT_EN to exercise the watchdog build.
module tb_scale_cfg_sequencer;

  localparam logic [1:0] K_LOAD  = 2'd0;
  localparam logic [1:0] K_START = 2'd1;
  localparam logic [1:0] K_DONE  = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  ch;
    logic [15:0] dat;
    logic [15:0] run;
    int          cyc;
  } exp_t;

  logic        clk, rst_n;
  logic        wr_en, tbl_clr, go, abort, stateinter;
  logic [4:0]  wr_choice;
  logic [15:0] wr_data, repeat_n;
  logic        scaleload, scalstart, busy, done, tbl_full, err_timeout;
  logic [4:0]  scalechoice;
  logic [15:0] scaledatain, run_cnt;
  logic [4:0]  tbl_cnt;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [4:0]  m_ch[16];
  logic [15:0] m_dat[16];
  int          m_n = 0;

  scale_cfg_sequencer #(.DEPTH(16), .AW(4), .TMO_W(24), .TMO_CYCLES(24'd100)) u_dut (
    .clk_sys(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_choice(wr_choice), .wr_data(wr_data),
    .tbl_clr(tbl_clr), .go(go), .abort(abort), .repeat_n(repeat_n), .stateinter(stateinter),
    .scaleload(scaleload), .scalechoice(scalechoice), .scaledatain(scaledatain),
    .scalstart(scalstart), .busy(busy), .done(done), .tbl_full(tbl_full), .tbl_cnt(tbl_cnt),
    .run_cnt(run_cnt), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_evt(input logic [1:0] kind);
    exp_t e;
    logic ok;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL evt_unexpected: kind %0d at cycle %0d with nothing expected", kind, cyc);
      return;
    end
    e  = q.pop_front();
    ok = (e.kind == kind);
    if (kind == K_LOAD) ok = ok && (scalechoice == e.ch) && (scaledatain == e.dat);
    if (kind == K_DONE) ok = ok && (run_cnt == e.run) && !busy;
    if (e.cyc >= 0)     ok = ok && (cyc == e.cyc);
    if (!ok) begin
      n_err++;
      $display("FAIL evt: got kind %0d ch %h dat %h run %0d cyc %0d, want kind %0d ch %h dat %h run %0d cyc %0d",
               kind, scalechoice, scaledatain, run_cnt, cyc, e.kind, e.ch, e.dat, e.run, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (scaleload) check_evt(K_LOAD);
      if (scalstart) check_evt(K_START);
      if (done)      check_evt(K_DONE);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int base);
    for (int i = 0; i < m_n; i++)
      q.push_back('{K_LOAD, m_ch[i], m_dat[i], 16'd0, (base < 0) ? -1 : base + 1 + 2 * i});
    q.push_back('{K_START, 5'd0, 16'd0, 16'd0, (base < 0) ? -1 : base + 1 + 2 * m_n});
  endtask

  task automatic go_seq(input logic [15:0] rep, input int runs, input bit with_done,
                        input logic [15:0] final_run);
    int base;
    base = cyc;
    for (int r = 0; r < runs; r++) push_run((r == 0) ? base : -1);
    if (with_done) q.push_back('{K_DONE, 5'd0, 16'd0, final_run, -1});
    go = 1'b1;
    repeat_n = rep;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_start();
    int k;
    k = 0;
    while (!scalstart && k < 400) begin
      tick();
      k++;
    end
    if (!scalstart) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_start: scalstart 0 after %0d cycles, want 1", k);
    end
  endtask

  task automatic pulse_si();
    stateinter = 1'b0;
    tick();
    stateinter = 1'b1;
  endtask

  task automatic finish_runs(input int runs);
    for (int r = 0; r < runs; r++) begin
      wait_start();
      tick();
      pulse_si();
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic wr(input logic [4:0] c, input logic [15:0] d);
    wr_en = 1'b1;
    wr_choice = c;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_table3();
    tbl_clr = 1'b1;
    tick();
    tbl_clr = 1'b0;
    wr(5'd1, 16'h0010);
    wr(5'd2, 16'h0020);
    wr(5'd3, 16'h0030);
    m_ch[0] = 5'd1; m_dat[0] = 16'h0010;
    m_ch[1] = 5'd2; m_dat[1] = 16'h0020;
    m_ch[2] = 5'd3; m_dat[2] = 16'h0030;
    m_n = 3;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; tbl_clr = 1'b0; go = 1'b0; abort = 1'b0;
    stateinter = 1'b1; wr_choice = '0; wr_data = '0; repeat_n = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {scaleload, scalstart, busy, done, tbl_full, err_timeout}, 0);
    chk("rst_data", {scalechoice, scaledatain}, 0);
    chk("rst_cnts", {tbl_cnt, run_cnt}, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    // T1: three entries, one run
    load_table3();
    chk("t1_tbl_cnt", tbl_cnt, 3);
    go_seq(16'd1, 1, 1'b1, 16'd1);
    wait_start();
    tick();
    pulse_si();
    tick();
    chk("t1_done", {done, busy}, 2'b10);
    drain();
    chk("t1_run_cnt", run_cnt, 1);

    // T2: repeat 0 runs once; repeat 3 runs three times
    go_seq(16'd0, 1, 1'b1, 16'd1);
    finish_runs(1);
    drain();
    chk("t2_rep0_run_cnt", run_cnt, 1);
    go_seq(16'd3, 3, 1'b1, 16'd3);
    finish_runs(3);
    drain();
    chk("t2_rep3_run_cnt", run_cnt, 3);

    // T3: overfill, then replay the 16 kept entries, then go on an empty table
    tbl_clr = 1'b1;
    tick();
    tbl_clr = 1'b0;
    chk("t3_clr_cnt", tbl_cnt, 0);
    for (int i = 0; i < 16; i++) begin
      wr(5'(i), 16'hA000 + 16'(i));
      m_ch[i] = 5'(i);
      m_dat[i] = 16'hA000 + 16'(i);
      if (i == 14) chk("t3_not_full_15", tbl_full, 0);
    end
    m_n = 16;
    chk("t3_full_16", {tbl_full, tbl_cnt}, {1'b1, 5'd16});
    wr(5'h1F, 16'hDEAD);
    chk("t3_17th_dropped", tbl_cnt, 16);
    go_seq(16'd1, 1, 1'b1, 16'd1);
    finish_runs(1);
    drain();
    tbl_clr = 1'b1;
    tick();
    tbl_clr = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("t3_empty_go_busy", busy, 0);
    tick();
    chk("t3_empty_go_busy2", busy, 0);

    // T4: stateinter low before go; a fall during GAP must not complete the run
    load_table3();
    stateinter = 1'b0;
    go_seq(16'd1, 1, 1'b1, 16'd1);
    stateinter = 1'b1;
    tick();
    stateinter = 1'b0;
    tick();
    wait_start();
    repeat (10) tick();
    chk("t4_still_busy", {busy, run_cnt}, {1'b1, 16'd0});
    chk("t4_done_pending", q.size(), 1);
    stateinter = 1'b1;
    tick();
    pulse_si();
    drain();
    chk("t4_run_cnt", run_cnt, 1);

    // T5: abort in WAIT of run 2 of 3; go and writes while busy are ignored
    go_seq(16'd3, 2, 1'b0, 16'd0);
    finish_runs(1);
    wait_start();
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    wr(5'h1F, 16'hBEEF);
    chk("t5_wr_busy_cnt", tbl_cnt, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_idle", {busy, scaleload, scalstart}, 0);
    chk("t5_abort_run_cnt", run_cnt, 1);
    drain();
    go_seq(16'd1, 1, 1'b1, 16'd1);
    finish_runs(1);
    drain();

    // T6: watchdog (timeout build) or wait-forever (default build)
    go_seq(16'd1, 1, 1'b0, 16'd0);
    wait_start();
`ifdef SCALE_SEQ_TIMEOUT_EN
    repeat (100) tick();
    chk("t6_wait100_busy", {busy, err_timeout}, 2'b10);
    tick();
    chk("t6_timeout", {busy, done, err_timeout}, 3'b001);
    go_seq(16'd1, 1, 1'b1, 16'd1);
    chk("t6_err_cleared", err_timeout, 0);
    finish_runs(1);
    drain();
`else
    repeat (150) tick();
    chk("t6_wait_forever", {busy, err_timeout}, 2'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_idle", busy, 0);
    drain();
`endif

    // Reset mid-sequence: outputs and table count clear at once
    q.push_back('{K_LOAD, m_ch[0], m_dat[0], 16'd0, cyc + 1});
    go = 1'b1;
    repeat_n = 16'd1;
    tick();
    go = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {scaleload, scalstart, busy, done}, 0);
    chk("rst_mid_tbl", {tbl_cnt, scalechoice}, 0);
    chk("rst_mid_q", q.size(), 0);
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
